// File: rtl/mux_nto1_seq.sv
// N-to-1 registered channel selector with break-before-make blanking between
// channel changes and an optional round-robin auto-scan driven by a dwell count.
module mux_nto1_seq #(
  parameter int  WIDTH = 8,
  parameter int  N     = 4,
  parameter int  BLANK = 2,
  parameter int  DW    = 4,
  localparam int SW    = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] i,
  input  logic [SW-1:0]      s,
  input  logic               s_load,
  input  logic               mode,
  input  logic [DW-1:0]      dwell,
  output logic [WIDTH-1:0]   o,
  output logic [SW-1:0]      o_sel,
  output logic               o_valid,
  output logic               sw,
  output logic               err
);

  localparam int BW = (BLANK > 2) ? $clog2(BLANK) : 1;

  typedef enum logic {ST_BLANK = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [WIDTH-1:0]  o_q, o_d;
  logic [SW-1:0]     o_sel_q, o_sel_d;
  logic              sw_q, sw_d;
  logic              err_q, err_d;
  logic              mode_q, mode_d;

  logic              req_ok, req_bad, adv, take, blank_done, mode_chg;
  logic [SW-1:0]     nxt_sel, scan_sel;
  logic [DW:0]       dwell_lim, dcnt_inc;

  function automatic logic [WIDTH-1:0] chan(input logic [N*WIDTH-1:0] bus,
                                            input logic [SW-1:0]      k);
    return bus[int'(k)*WIDTH +: WIDTH];
  endfunction

  // Switch decisions: a valid manual request always beats a scan advance.
  assign req_ok     = s_load && (int'(s) < N) && (s != o_sel_q);
  assign req_bad    = s_load && (int'(s) >= N);
  assign mode_chg   = (mode != mode_q);
  assign dwell_lim  = (dwell == '0) ? (DW+1)'(1) : {1'b0, dwell};
  assign dcnt_inc   = {1'b0, dcnt_q} + 1'b1;
  assign adv        = (state_q == ST_RUN) && mode && !mode_chg && (dcnt_inc >= dwell_lim);
  assign take       = req_ok || adv;
  assign scan_sel   = (o_sel_q == SW'(N-1)) ? '0 : o_sel_q + 1'b1;
  assign nxt_sel    = req_ok ? s : scan_sel;
  assign blank_done = (BLANK == 0) || (int'(bcnt_q) >= BLANK - 1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (take) begin
      state_d = (BLANK == 0) ? ST_RUN : ST_BLANK;
    end else if (state_q == ST_BLANK && blank_done) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    o_d     = o_q;
    o_sel_d = o_sel_q;
    sw_d    = 1'b0;
    err_d   = req_bad;
    mode_d  = mode;
    if (take) begin
      o_sel_d = nxt_sel;
      sw_d    = 1'b1;
      bcnt_d  = '0;
      dcnt_d  = '0;
      o_d     = (BLANK == 0) ? chan(i, nxt_sel) : '0;
    end else if (state_q == ST_BLANK) begin
      dcnt_d = '0;
      if (blank_done) begin
        bcnt_d = '0;
        o_d    = chan(i, o_sel_q);
      end else begin
        bcnt_d = bcnt_q + 1'b1;
        o_d    = '0;
      end
    end else begin
      o_d = chan(i, o_sel_q);
      // Manual mode and the cycle of a mode flip both hold the dwell count at zero.
      if (mode && !mode_chg) dcnt_d = dcnt_inc[DW-1:0];
      else                   dcnt_d = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BLANK;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      o_q     <= '0;
      o_sel_q <= '0;
      sw_q    <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      o_q     <= o_d;
      o_sel_q <= o_sel_d;
      sw_q    <= sw_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs
  always_comb begin
    o       = o_q;
    o_sel   = o_sel_q;
    o_valid = (state_q == ST_RUN);
    sw      = sw_q;
    err     = err_q;
  end

endmodule

// File: doc/mux_nto1_seq.md
MUX_NTO1_SEQ -- requirements
Module: mux_nto1_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter N, default 4, channel count (N >= 2); SW = ceil(log2(N)).
REQ-003 SHALL have parameter BLANK, default 2, break-before-make blanking cycles (0 allowed).
REQ-004 SHALL have parameter DW, default 4, dwell input width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i  input  N*WIDTH  flat channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port s  input  SW  requested channel.
REQ-009 SHALL have port s_load  input  1  one-cycle request to switch to channel s.
REQ-010 SHALL have port mode  input  1  0 = manual select, 1 = auto-scan round-robin.
REQ-011 SHALL have port dwell  input  DW  cycles spent in RUN per channel in scan mode.
REQ-012 SHALL have port o  output  WIDTH  registered selected data.
REQ-013 SHALL have port o_sel  output  SW  currently selected channel.
REQ-014 SHALL have port o_valid  output  1  high when o carries live data of o_sel.
REQ-015 SHALL have port sw  output  1  one-cycle pulse on every accepted channel change.
REQ-016 SHALL have port err  output  1  one-cycle pulse when s_load requests s >= N.

Function
REQ-017 SHALL implement two states: RUN (o_valid=1) and BLANK (o_valid=0, o=0).
REQ-018 SHALL in RUN register o <= i[o_sel] every cycle: one-cycle latency from i to o.
REQ-019 SHALL in BLANK count BLANK cycles, then enter RUN; first live o appears on the cycle after the last BLANK cycle.
REQ-020 SHALL with BLANK=0 skip BLANK: switch cycle goes straight to RUN sampling the new channel.
REQ-021 SHALL on accepted switch: o_sel <= new channel, sw=1 next cycle, state <= BLANK, blank counter restarted.
REQ-022 SHALL accept s_load (either mode) when s < N and s != o_sel.
REQ-023 SHALL ignore s_load with s == o_sel: no sw, no blanking, state unchanged.
REQ-024 SHALL ignore s_load with s >= N except err=1 next cycle; o_sel and state unchanged.
REQ-025 SHALL accept s_load during BLANK, restarting the full BLANK count.
REQ-026 SHALL in scan mode count RUN cycles; when count reaches max(dwell,1), advance o_sel to (o_sel==N-1) ? 0 : o_sel+1 as an accepted switch.
REQ-027 SHALL clear the dwell count on entering RUN, on any accepted switch and on any mode change.
REQ-028 SHALL give accepted s_load priority over a scan advance in the same cycle (single switch, to s).
REQ-029 SHALL not count dwell during BLANK; manual mode never auto-advances.
REQ-030 SHALL sample dwell continuously; a new value applies to the current count comparison.

Reset
REQ-031 SHALL on rst_n=0 immediately force o=0, o_sel=0, o_valid=0, sw=0, err=0, dwell count=0, state=BLANK with full count.
REQ-032 SHALL after rst_n release run BLANK cycles then enter RUN on channel 0 (no sw pulse).
REQ-033 SHALL on reset mid-BLANK or mid-dwell discard all progress.

Verification
REQ-034 SHALL cover: N=4,WIDTH=8,BLANK=2, i={8'h44,8'h33,8'h22,8'h11}, reset release -> o_valid low 2 cycles, then o=8'h11, o_sel=0.
REQ-035 SHALL cover: manual, s=2,s_load=1 one cycle -> sw pulse, o=0/o_valid=0 for 2 cycles, then o=8'h33, o_sel=2.
REQ-036 SHALL cover: s_load with s=o_sel -> no sw, o_valid stays 1; N=3 bench, s=3 -> err pulse, o_sel unchanged.
REQ-037 SHALL cover: mode=1, dwell=3 -> o_sel sequence 0,1,2,3,0 with 3 live cycles then 2 blank per channel; dwell=0 -> 1 live cycle each.
REQ-038 SHALL cover: scan advance cycle coincident with s_load s=3 -> single switch to 3; rst_n low mid-BLANK -> all outputs 0 asynchronously, restart at channel 0.
